// File: rtl/seq_divider8.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit
// per cycle, with early-out divide-by-zero and quotient-overflow detection.
module seq_divider8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic               ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e r_state, w_state_d;

  logic [WIDTH-1:0] r_rem, r_shreg, r_div, r_quot, r_remo;
  logic [CntW-1:0]  r_cnt;
  logic             r_dbz, r_ovf;

  logic [WIDTH:0]   w_trial, w_diff, w_shift;
  logic             w_ge, w_last, w_is_dbz, w_is_ovf;
  logic [WIDTH-1:0] w_rem_nxt, w_shreg_nxt;

  // Datapath for one restoring step; r_shreg shifts dividend bits out and quotient bits in.
  always_comb begin
    w_trial     = {r_rem, r_shreg[WIDTH-1]};
    w_diff      = w_trial - {1'b0, r_div};
    w_ge        = (w_trial >= {1'b0, r_div});
    w_rem_nxt   = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_shift     = {r_shreg, w_ge};
    w_shreg_nxt = w_shift[WIDTH-1:0];
    w_last      = (r_cnt == CntW'(WIDTH - 1));
    w_is_dbz    = (divisor == '0);
    w_is_ovf    = (dividend[2*WIDTH-1:WIDTH] >= divisor);
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = (w_is_dbz || w_is_ovf) ? StDone : StRun;
        end
      end
      StRun:   if (w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_shreg <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_dbz <= w_is_dbz;
            r_ovf <= !w_is_dbz && w_is_ovf;
            if (w_is_dbz) begin
              r_quot <= '1;
              r_remo <= dividend[WIDTH-1:0];
            end else if (w_is_ovf) begin
              r_quot <= '1;
              r_remo <= '0;
            end else begin
              r_rem   <= dividend[2*WIDTH-1:WIDTH];
              r_shreg <= dividend[WIDTH-1:0];
              r_div   <= divisor;
              r_cnt   <= '0;
            end
          end
        end
        StRun: begin
          r_rem   <= w_rem_nxt;
          r_shreg <= w_shreg_nxt;
          if (w_last) begin
            r_cnt  <= '0;
            r_quot <= w_shreg_nxt;
            r_remo <= w_rem_nxt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;
  assign busy      = (r_state == StRun);
  assign done      = (r_state == StDone);

endmodule

// File: tb/tb_seq_divider8.sv
// Bench for seq_divider8: arithmetic reference model checked every cycle plus directed
// vectors with literal expected results, latencies and reset behaviour.
module tb_seq_divider8;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [15:0]  dividend;
  logic [7:0]   divisor;
  logic [7:0]   quotient, remainder;
  logic         busy, done, dbz, ovf;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: cycles of work left, pending result, visible result.
  int         m_left = 0;
  bit         m_done = 0, m_valid = 0, m_dbz = 0, m_ovf = 0, m_last_normal = 0;
  logic [7:0] m_q = 0, m_r = 0, p_q = 0, p_r = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_valid = 1; m_dbz = 0; m_ovf = 0; m_q = 0; m_r = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_valid = 1; m_q = p_q; m_r = p_r; m_dbz = 0; m_ovf = 0;
        m_last_normal = 1;
      end
    end else if (start) begin
      if (divisor == 0) begin
        m_done = 1; m_valid = 1; m_dbz = 1; m_ovf = 0; m_q = 8'hFF; m_r = dividend[7:0];
        m_last_normal = 0;
      end else if (dividend[15:8] >= divisor) begin
        m_done = 1; m_valid = 1; m_dbz = 0; m_ovf = 1; m_q = 8'hFF; m_r = 8'h00;
        m_last_normal = 0;
      end else begin
        m_left = W; m_valid = 0;
        p_q = 8'(dividend / divisor);
        p_r = 8'(dividend % divisor);
      end
    end
  end

  bit chk_en = 0, spacing_en = 0;
  int cyc = 0, last_done_cyc = -1, rnd_dones = 0;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      if (m_valid) begin
        check("quotient", quotient, m_q);
        check("remainder", remainder, m_r);
        check("dbz", dbz, m_dbz);
        check("ovf", ovf, m_ovf);
      end
      if (done && spacing_en) begin
        rnd_dones++;
        if (last_done_cyc >= 0)
          check("done_spacing", cyc - last_done_cyc, m_last_normal ? W + 2 : 2);
        last_done_cyc = cyc;
      end
    end
  end

  task automatic do_op(input string name, input logic [15:0] dd, input logic [7:0] dv,
                       input logic [7:0] eq, input logic [7:0] er, input bit edbz,
                       input bit eovf, input int elat);
    int lat;
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, elat);
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dbz"}, dbz, edbz);
    check({name, "_ovf"}, ovf, eovf);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit seen;
    int sel;
    logic [7:0] hi, lo, dv;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    chk_en = 1;

    do_op("d1000_7",  16'h03E8, 8'd7,   8'd142,  8'd6,   0, 0, W + 1);
    do_op("dfe01_ff", 16'hFE01, 8'hFF,  8'hFF,   8'h00,  0, 0, W + 1);
    do_op("dffff_ff", 16'hFFFF, 8'hFF,  8'hFF,   8'h00,  0, 1, 1);
    do_op("d1234_0",  16'h1234, 8'h00,  8'hFF,   8'h34,  1, 0, 1);
    do_op("d00ff_1",  16'h00FF, 8'h01,  8'hFF,   8'h00,  0, 0, W + 1);
    do_op("d0100_1",  16'h0100, 8'h01,  8'hFF,   8'h00,  0, 1, 1);
    do_op("d0000_5",  16'h0000, 8'h05,  8'h00,   8'h00,  0, 0, W + 1);

    // Second start during RUN must be ignored.
    @(negedge clk);
    dividend = 16'h0064; divisor = 8'h0A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 3) begin
        dividend = 16'h00FF; divisor = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("repulse_lat", lat, W + 1);
    check("repulse_q", quotient, 8'd10);
    check("repulse_r", remainder, 8'd0);
    @(posedge clk); #1;

    // Reset on the 4th RUN cycle, with start high on the reset edge.
    @(negedge clk);
    dividend = 16'h03E8; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", dbz, 0);
    check("abort_ovf", ovf, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("abort_no_done", seen, 0);
    do_op("after_abort", 16'h03E8, 8'd7, 8'd142, 8'd6, 0, 0, W + 1);

    // Back-to-back regression with start held high.
    @(negedge clk);
    spacing_en = 1; last_done_cyc = -1;
    start = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      sel = $urandom_range(0, 9);
      lo = 8'($urandom);
      if (sel == 0) begin
        dv = 8'h00; hi = 8'($urandom);
      end else if (sel == 1) begin
        dv = 8'($urandom_range(1, 255)); hi = 8'($urandom_range(dv, 255));
      end else begin
        dv = 8'($urandom_range(1, 255)); hi = 8'($urandom_range(0, dv - 1));
      end
      dividend = {hi, lo}; divisor = dv;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    spacing_en = 0;
    check("rnd_enough_dones", rnd_dones > 1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
